mfcc_frame_buffer: RTL and testbench
====================================

MFCC_FRAME_BUFFER -- requirements
Module: mfcc_frame_buffer

Interface
REQ-001 Parameter D_WL, default 24, width of one MFCC word.
REQ-002 Parameter INPUT_SIZE, default 26, words per frame.
REQ-003 Parameter NUM_FRAMES, default 148, frames per utterance.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 d_i_valid  input  1  upstream UART interface word strobe.
REQ-007 d_i  input  D_WL  upstream word, sampled when d_i_valid=1.
REQ-008 w_x_en  output  1  one-cycle request to upstream for the next frame.
REQ-009 frame_ready  output  1  a full bank is available for draining.
REQ-010 frame_start  input  1  consumer pulse that starts a drain.
REQ-011 x_o_valid  output  1  drain data strobe.
REQ-012 x_o  output  D_WL  drained word.
REQ-013 x_o_last  output  1  marks the final word of a drained frame.
REQ-014 all_done  output  1  sticky; all NUM_FRAMES frames drained.
REQ-015 overflow  output  1  sticky; an input word was dropped.

Function
REQ-016 The block SHALL hold two banks (B0, B1) of INPUT_SIZE x D_WL words, each bank in state EMPTY or FULL.
REQ-017 The write FSM SHALL have states W_IDLE and W_FILL, with wr_bank, wr_ptr (0..INPUT_SIZE-1) and frames_req (0..NUM_FRAMES).
REQ-018 In W_IDLE, if bank[wr_bank]=EMPTY and frames_req<NUM_FRAMES, the FSM SHALL pulse w_x_en for exactly one cycle, increment frames_req, and enter W_FILL.
REQ-019 In W_FILL, each d_i_valid=1 cycle SHALL write d_i to bank[wr_bank][wr_ptr] and increment wr_ptr.
REQ-020 The write with wr_ptr=INPUT_SIZE-1 SHALL set bank[wr_bank]=FULL, clear wr_ptr, toggle wr_bank, and return to W_IDLE.
REQ-021 d_i_valid=1 in W_IDLE SHALL drop the word and set overflow; no bank contents change.
REQ-022 The read FSM SHALL have states R_IDLE and R_DRAIN, with rd_bank, rd_ptr, and frames_out (0..NUM_FRAMES).
REQ-023 frame_ready SHALL equal (read FSM in R_IDLE) AND (bank[rd_bank]=FULL).
REQ-024 frame_start with frame_ready=1 SHALL enter R_DRAIN; frame_start at any other time SHALL be ignored.
REQ-025 The drain SHALL output words 0..INPUT_SIZE-1 on INPUT_SIZE consecutive cycles, the first on the cycle after frame_start, with x_o_valid=1 throughout.
REQ-026 x_o_last SHALL be 1 only with word INPUT_SIZE-1; x_o SHALL hold its last value when x_o_valid=0.
REQ-027 On the x_o_last cycle the FSM SHALL set bank[rd_bank]=EMPTY, toggle rd_bank, increment frames_out, and return to R_IDLE.
REQ-028 all_done SHALL rise the cycle after frames_out reaches NUM_FRAMES and stay 1 until reset; no further w_x_en pulses SHALL occur once frames_req=NUM_FRAMES.
REQ-029 Simultaneous fill completion and drain completion on different banks SHALL both take effect in the same cycle.
REQ-030 A bank freed while the write FSM is in W_IDLE SHALL produce a w_x_en pulse on the following cycle.
REQ-031 Counters SHALL never wrap; frames_req and frames_out saturate at NUM_FRAMES.

Reset
REQ-032 rst_n=0 SHALL immediately force w_x_en, frame_ready, x_o_valid, x_o_last, all_done and overflow to 0, x_o to 0, both banks EMPTY, all pointers and counters to 0, wr_bank=rd_bank=B0, FSMs to W_IDLE/R_IDLE.
REQ-033 Reset asserted mid-fill or mid-drain SHALL discard the partial frame; the first w_x_en SHALL be issued 1 cycle after rst_n deasserts.

Verification
REQ-034 Release reset, drive 26 valid words 0x000001..0x00001A -> single w_x_en pulse, frame_ready=1 after the 26th word, second w_x_en for B1.
REQ-035 Pulse frame_start -> x_o_valid for 26 cycles starting the next cycle, x_o=0x000001..0x00001A, x_o_last only on 0x00001A, frame_ready=0.
REQ-036 Fill B0 and B1 without draining, then drive 1 more valid word -> word dropped, overflow=1, no third w_x_en until a drain finishes.
REQ-037 Finish filling B1 on the same cycle as the B0 drain's x_o_last -> B0 EMPTY, B1 FULL, w_x_en next cycle, frame_ready=1.
REQ-038 Run 148 fill/drain frames -> exactly 148 w_x_en pulses, all_done=1 after the 148th x_o_last, no w_x_en afterwards.
REQ-039 Assert rst_n=0 at word 13 of a drain -> all outputs 0 immediately; after release, new frames start at B0, word 0.

Source files
------------

// File: rtl/mfcc_frame_buffer.sv
// Ping-pong frame buffer between an upstream MFCC word source and a frame consumer.
// Two banks of INPUT_SIZE words are filled and drained alternately by independent write/read FSMs.
module mfcc_frame_buffer #(
    parameter int unsigned D_WL       = 24,
    parameter int unsigned INPUT_SIZE = 26,
    parameter int unsigned NUM_FRAMES = 148
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            d_i_valid,
    input  logic [D_WL-1:0] d_i,
    output logic            w_x_en,
    output logic            frame_ready,
    input  logic            frame_start,
    output logic            x_o_valid,
    output logic [D_WL-1:0] x_o,
    output logic            x_o_last,
    output logic            all_done,
    output logic            overflow
);

    localparam int unsigned PTR_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_FRAMES + 1);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(INPUT_SIZE - 1);
    localparam logic [CNT_W-1:0] MAX_FRAMES = CNT_W'(NUM_FRAMES);

    typedef enum logic {W_IDLE, W_FILL}  wr_state_t;
    typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;

    // Write side state
    wr_state_t        wr_state, wr_state_d;
    logic             wr_bank, wr_bank_d;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_d;
    logic [CNT_W-1:0] frames_req, frames_req_d;
    logic             w_x_en_d;
    logic             overflow_d;
    logic             wr_en;
    logic             fill_done;

    // Read side state
    rd_state_t        rd_state, rd_state_d;
    logic             rd_bank, rd_bank_d;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_d;
    logic [CNT_W-1:0] frames_out, frames_out_d;
    logic             x_o_valid_d;
    logic             x_o_last_d;
    logic [D_WL-1:0]  x_o_d;
    logic             drain_done;

    // Shared bank status and derived outputs
    logic [1:0]       bank_full, bank_full_d;
    logic             frame_ready_d;
    logic             all_done_d;

    logic [D_WL-1:0]  mem [2][INPUT_SIZE];

    // Frame storage; contents are only meaningful while the owning bank is FULL
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_ptr] <= d_i;
        end
    end

    // Write FSM: request a frame when the target bank is free, then fill it
    always_comb begin
        wr_state_d   = wr_state;
        wr_bank_d    = wr_bank;
        wr_ptr_d     = wr_ptr;
        frames_req_d = frames_req;
        w_x_en_d     = 1'b0;
        overflow_d   = overflow;
        wr_en        = 1'b0;
        fill_done    = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (d_i_valid) begin
                    overflow_d = 1'b1;
                end
                if (!bank_full[wr_bank] && (frames_req < MAX_FRAMES)) begin
                    w_x_en_d     = 1'b1;
                    frames_req_d = frames_req + CNT_W'(1);
                    wr_state_d   = W_FILL;
                end
            end
            W_FILL: begin
                if (d_i_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr == LAST_PTR) begin
                        fill_done  = 1'b1;
                        wr_ptr_d   = '0;
                        wr_bank_d  = ~wr_bank;
                        wr_state_d = W_IDLE;
                    end else begin
                        wr_ptr_d = wr_ptr + PTR_W'(1);
                    end
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read FSM: rd_ptr is zero in R_IDLE, so the first word is addressed the same way as the rest
    always_comb begin
        rd_state_d   = rd_state;
        rd_bank_d    = rd_bank;
        rd_ptr_d     = rd_ptr;
        frames_out_d = frames_out;
        x_o_valid_d  = 1'b0;
        x_o_last_d   = 1'b0;
        x_o_d        = x_o;
        drain_done   = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (frame_start && frame_ready) begin
                    x_o_valid_d = 1'b1;
                    x_o_d       = mem[rd_bank][rd_ptr];
                    rd_ptr_d    = rd_ptr + PTR_W'(1);
                    rd_state_d  = R_DRAIN;
                end
            end
            R_DRAIN: begin
                x_o_valid_d = 1'b1;
                x_o_d       = mem[rd_bank][rd_ptr];
                if (rd_ptr == LAST_PTR) begin
                    x_o_last_d = 1'b1;
                    drain_done = 1'b1;
                    rd_ptr_d   = '0;
                    rd_bank_d  = ~rd_bank;
                    rd_state_d = R_IDLE;
                    if (frames_out != MAX_FRAMES) begin
                        frames_out_d = frames_out + CNT_W'(1);
                    end
                end else begin
                    rd_ptr_d = rd_ptr + PTR_W'(1);
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Fill and drain always target different banks, so both updates may land together
    always_comb begin
        bank_full_d = bank_full;
        if (fill_done) begin
            bank_full_d[wr_bank] = 1'b1;
        end
        if (drain_done) begin
            bank_full_d[rd_bank] = 1'b0;
        end
    end

    assign frame_ready_d = (rd_state_d == R_IDLE) && bank_full_d[rd_bank_d];
    assign all_done_d    = all_done | (frames_out == MAX_FRAMES);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state    <= W_IDLE;
            wr_bank     <= 1'b0;
            wr_ptr      <= '0;
            frames_req  <= '0;
            rd_state    <= R_IDLE;
            rd_bank     <= 1'b0;
            rd_ptr      <= '0;
            frames_out  <= '0;
            bank_full   <= '0;
            w_x_en      <= 1'b0;
            frame_ready <= 1'b0;
            x_o_valid   <= 1'b0;
            x_o         <= '0;
            x_o_last    <= 1'b0;
            all_done    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wr_state    <= wr_state_d;
            wr_bank     <= wr_bank_d;
            wr_ptr      <= wr_ptr_d;
            frames_req  <= frames_req_d;
            rd_state    <= rd_state_d;
            rd_bank     <= rd_bank_d;
            rd_ptr      <= rd_ptr_d;
            frames_out  <= frames_out_d;
            bank_full   <= bank_full_d;
            w_x_en      <= w_x_en_d;
            frame_ready <= frame_ready_d;
            x_o_valid   <= x_o_valid_d;
            x_o         <= x_o_d;
            x_o_last    <= x_o_last_d;
            all_done    <= all_done_d;
            overflow    <= overflow_d;
        end
    end

endmodule

// File: tb/tb_mfcc_frame_buffer.sv
// Bench for mfcc_frame_buffer: a frame-count/word-queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mfcc_frame_buffer;

    localparam int unsigned DW = 24;
    localparam int unsigned IS = 26;
    localparam int unsigned NF = 148;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          d_i_valid;
    logic [DW-1:0] d_i;
    logic          w_x_en;
    logic          frame_ready;
    logic          frame_start;
    logic          x_o_valid;
    logic [DW-1:0] x_o;
    logic          x_o_last;
    logic          all_done;
    logic          overflow;

    mfcc_frame_buffer #(.D_WL(DW), .INPUT_SIZE(IS), .NUM_FRAMES(NF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .d_i_valid   (d_i_valid),
        .d_i         (d_i),
        .w_x_en      (w_x_en),
        .frame_ready (frame_ready),
        .frame_start (frame_start),
        .x_o_valid   (x_o_valid),
        .x_o         (x_o),
        .x_o_last    (x_o_last),
        .all_done    (all_done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Model state: frames requested, words accepted, frames started/drained
    int            m_reqs, m_words, m_starts, m_drained, m_left;
    logic [DW-1:0] mq[$];
    logic          e_wx, e_ready, e_valid, e_last, e_done, e_ovf;
    logic [DW-1:0] e_xo;

    // Observed activity since the last reset, used for pacing and literal checks
    int            wx_count, drained_count, frames_sent;
    logic [DW-1:0] seen[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] base);
        int t = 0;
        while (wx_count <= frames_sent && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("wx_wait", 32'(wx_count > frames_sent), 32'd1);
        for (int i = 0; i < IS; i++) begin
            @(negedge clk);
            d_i_valid = 1'b1;
            d_i       = base + DW'(i);
        end
        @(negedge clk);
        d_i_valid = 1'b0;
        frames_sent++;
    endtask

    task automatic drain_one();
        int t = 0;
        int target;
        target = drained_count + 1;
        while (!frame_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", 32'(frame_ready), 32'd1);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        t = 0;
        while (drained_count < target && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_wait", 32'(drained_count >= target), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_w_x_en"},      32'(w_x_en),      32'd0);
        check({tag, "_frame_ready"}, 32'(frame_ready), 32'd0);
        check({tag, "_x_o_valid"},   32'(x_o_valid),   32'd0);
        check({tag, "_x_o"},         32'(x_o),         32'd0);
        check({tag, "_x_o_last"},    32'(x_o_last),    32'd0);
        check({tag, "_all_done"},    32'(all_done),    32'd0);
        check({tag, "_overflow"},    32'(overflow),    32'd0);
    endtask

    initial begin
        rst_n       = 1'b1;
        d_i_valid   = 1'b0;
        d_i         = '0;
        frame_start = 1'b0;
        frames_sent = 0;
        wx_count    = 0;
        drained_count = 0;

        fork
            // Behavioural model: banks are just "frames held = requested - drained"
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    m_reqs = 0; m_words = 0; m_starts = 0; m_drained = 0; m_left = 0;
                    mq.delete();
                    e_wx = 0; e_ready = 0; e_valid = 0; e_last = 0;
                    e_done = 0; e_ovf = 0; e_xo = '0;
                end else begin
                    bit idle_w;
                    int pre_drained;
                    bit pre_ready;
                    pre_drained = m_drained;
                    pre_ready   = e_ready;
                    idle_w      = (m_words == m_reqs * IS);
                    e_done      = e_done | (pre_drained == NF);
                    if (d_i_valid) begin
                        if (idle_w) e_ovf = 1'b1;
                        else begin
                            mq.push_back(d_i);
                            m_words++;
                        end
                    end
                    e_wx = idle_w && (m_reqs - pre_drained < 2) && (m_reqs < NF);
                    if (e_wx) m_reqs++;
                    e_valid = 1'b0;
                    e_last  = 1'b0;
                    if (m_left == 0 && frame_start && pre_ready) begin
                        m_starts++;
                        m_left = IS;
                    end
                    if (m_left > 0) begin
                        e_valid = 1'b1;
                        e_xo    = (mq.size() > 0) ? mq.pop_front() : '0;
                        m_left--;
                        if (m_left == 0) begin
                            e_last = 1'b1;
                            m_drained++;
                        end
                    end
                    e_ready = (m_left == 0) && (m_words / IS > m_starts);
                end
            end
            // Compare process and activity monitor
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    wx_count      = 0;
                    drained_count = 0;
                    seen.delete();
                end else begin
                    check("w_x_en",      32'(w_x_en),      32'(e_wx));
                    check("frame_ready", 32'(frame_ready), 32'(e_ready));
                    check("x_o_valid",   32'(x_o_valid),   32'(e_valid));
                    check("x_o_last",    32'(x_o_last),    32'(e_last));
                    check("x_o",         32'(x_o),         32'(e_xo));
                    check("all_done",    32'(all_done),    32'(e_done));
                    check("overflow",    32'(overflow),    32'(e_ovf));
                    if (w_x_en)    wx_count++;
                    if (x_o_valid) seen.push_back(x_o);
                    if (x_o_last)  drained_count++;
                end
            end
        join_none

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        #2 rst_n = 1'b1;

        // One frame in, then request for the second bank
        send_frame(24'h000001);
        check("t1_ready", 32'(frame_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("t1_wx_count", 32'(wx_count), 32'd2);

        // Drain the first frame
        drain_one();
        check("t1_words",  32'(seen.size()), 32'd26);
        check("t1_first",  32'(seen[0]),     32'h000001);
        check("t1_last",   32'(seen[25]),    32'h00001A);
        check("t1_ready0", 32'(frame_ready), 32'd0);

        // Both banks full, then one extra word is dropped
        send_frame(24'h000101);
        send_frame(24'h000201);
        @(negedge clk);
        d_i_valid = 1'b1;
        d_i       = 24'h0BADBD;
        @(negedge clk);
        d_i_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("t2_overflow", 32'(overflow), 32'd1);
        check("t2_wx_count", 32'(wx_count), 32'd3);
        drain_one();
        repeat (3) @(negedge clk);
        check("t2_wx_after", 32'(wx_count), 32'd4);

        // Fill of B1 completes on the same edge as the B0 drain's last word
        for (int i = 0; i < IS; i++) begin
            @(negedge clk);
            d_i_valid   = 1'b1;
            d_i         = 24'h000301 + DW'(i);
            frame_start = (i == 0);
        end
        @(negedge clk);
        d_i_valid = 1'b0;
        frames_sent++;
        check("t3_last",  32'(x_o_last),    32'd1);
        check("t3_ready", 32'(frame_ready), 32'd1);
        @(posedge clk);
        #1 check("t3_wx_next", 32'(w_x_en), 32'd1);

        // Run the utterance to completion
        for (int k = 0; k < 200 && drained_count < NF; k++) begin
            if (frames_sent < NF) send_frame(DW'(frames_sent * 256));
            drain_one();
        end
        repeat (3) @(negedge clk);
        check("t4_all_done", 32'(all_done),      32'd1);
        check("t4_drained",  32'(drained_count), 32'd148);
        check("t4_wx_count", 32'(wx_count),      32'd148);
        repeat (20) @(negedge clk);
        check("t4_wx_final", 32'(wx_count),      32'd148);

        // Reset in the middle of a drain
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        frames_sent = 0;
        send_frame(24'h000200);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int t = 0; t < 40 && seen.size() < 13; t++) @(negedge clk);
        check("t5_mid_drain", 32'(x_o_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("t5_rst");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 check("t5_first_wx", 32'(w_x_en), 32'd1);
        frames_sent = 0;
        send_frame(24'h000100);
        drain_one();
        check("t5_words", 32'(seen.size()), 32'd26);
        check("t5_first", 32'(seen[0]),     32'h000100);
        check("t5_last",  32'(seen[25]),    32'h000119);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
